// File: rtl/fetch_ifid.sv
// Fetch stage with IF/ID pipeline register.
// Owns the fetch PC and drives a variable-latency instruction memory. The
// instruction words it receives are delivered to decode through the IF/ID
// register. A one-entry skid buffer catches a word that returns while decode
// is holding. Redirects squash the fetched path, and a HALT opcode stops fetch.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        dataMem_stall,
    input  logic        flush,
    input  logic [15:0] branchTarget,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instruction_fd,
    output logic [15:0] pcPlus2_fd,
    output logic [15:0] pc_f,
    output logic        instrMem_stall,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_SQUASH,
        S_SKID,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
    logic [15:0] addr_q;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic        hold;
    logic        req;
    logic        got;
    logic        word_halt;
    logic [15:0] pc_inc;

    // Request and stall outputs; the address in WAIT/SQUASH comes from the
    // latched copy because pc_f may already hold a redirect target.
    always_comb begin
        hold      = data_hazard | dataMem_stall;
        req       = !rst && (state_q == S_FETCH || state_q == S_WAIT ||
                             state_q == S_SQUASH);
        imem_addr = (state_q == S_FETCH) ? pc_q : addr_q;
        instrMem_stall = !rst && (state_q == S_WAIT || state_q == S_SQUASH ||
                                  (state_q == S_FETCH && !imem_done));
        got       = req && imem_done && (state_q != S_SQUASH);
        word_halt = (imem_rdata[15:11] == HALT_OPCODE);
        pc_inc    = pc_q + 16'd2;
    end

    assign imem_req       = req;
    assign pc_f           = pc_q;
    assign instruction_fd = instr_q;
    assign pcPlus2_fd     = pc2_q;
    assign halted         = halted_q;
    assign err            = err_q;

    // Next-state logic: flush overrides everything, otherwise per-state
    // handling of returned words, holds and bubbles.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc2_d        = pc2_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
        halted_d     = halted_q;
        err_d        = err_q;

        if (imem_done && !req) begin
            err_d = 1'b1;
        end

        if (flush) begin
            if (branchTarget[0]) begin
                err_d = 1'b1;
            end
            pc_d     = branchTarget;
            instr_d  = NOP_INSTR;
            halted_d = 1'b0;
            state_d  = (req && !imem_done) ? S_SQUASH : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH, S_WAIT: begin
                    if (got) begin
                        pc_d = pc_inc;
                        if (word_halt) begin
                            halted_d = 1'b1;
                        end
                        if (hold) begin
                            skid_instr_d = imem_rdata;
                            skid_pc2_d   = pc_inc;
                            state_d      = S_SKID;
                        end else begin
                            instr_d = imem_rdata;
                            pc2_d   = pc_inc;
                            state_d = word_halt ? S_HALT : S_FETCH;
                        end
                    end else begin
                        state_d = S_WAIT;
                        if (!hold) begin
                            instr_d = NOP_INSTR;
                        end
                    end
                end
                S_SQUASH: begin
                    if (imem_done) begin
                        state_d = S_FETCH;
                    end
                    if (!hold) begin
                        instr_d = NOP_INSTR;
                    end
                end
                S_SKID: begin
                    if (!hold) begin
                        instr_d = skid_instr_q;
                        pc2_d   = skid_pc2_q;
                        state_d = halted_q ? S_HALT : S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!hold) begin
                        instr_d = NOP_INSTR;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Control and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc2_q    <= 16'h0000;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Skid contents and the in-flight address; only meaningful while the
    // state says so, so they carry no reset.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc2_q   <= skid_pc2_d;
        addr_q       <= imem_addr;
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Testbench for fetch_ifid: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_ifid;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        data_hazard;
    logic        dataMem_stall;
    logic        flush;
    logic [15:0] branchTarget;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instruction_fd;
    logic [15:0] pcPlus2_fd;
    logic [15:0] pc_f;
    logic        instrMem_stall;
    logic        halted;
    logic        err;

    fetch_ifid dut (
        .clk            (clk),
        .rst            (rst),
        .data_hazard    (data_hazard),
        .dataMem_stall  (dataMem_stall),
        .flush          (flush),
        .branchTarget   (branchTarget),
        .imem_rdata     (imem_rdata),
        .imem_done      (imem_done),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .instruction_fd (instruction_fd),
        .pcPlus2_fd     (pcPlus2_fd),
        .pc_f           (pc_f),
        .instrMem_stall (instrMem_stall),
        .halted         (halted),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:32767];

    // Behavioural model: a PC, an in-flight request (with a "discard" mark),
    // a queue of words returned during hold, and the visible IF/ID contents.
    bit          m_known = 0;
    logic [15:0] m_pc, m_ins, m_p2, m_addr;
    bit          m_busy, m_drop, m_halted, m_err;
    logic [31:0] skidq [$];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic r, input logic dh, input logic ds, input logic fl,
                        input logic [15:0] bt, input logic dn);
        logic        e_req, e_stall, hold, valid;
        logic [15:0] e_addr, w, nx;
        rst = r; data_hazard = dh; dataMem_stall = ds; flush = fl;
        branchTarget = bt; imem_done = dn;
        e_req   = !r && (skidq.size() == 0) && !m_halted;
        e_addr  = m_busy ? m_addr : m_pc;
        e_stall = e_req && (m_busy || !dn);
        imem_rdata = dn ? mem[e_addr[15:1]] : 16'h5A5A;
        #2;
        if (m_known) begin
            chk1("imem_req", imem_req, e_req);
            if (e_req) chk16("imem_addr", imem_addr, e_addr);
            chk1("instrMem_stall", instrMem_stall, e_stall);
            chk16("instruction_fd", instruction_fd, m_ins);
            chk16("pcPlus2_fd", pcPlus2_fd, m_p2);
            chk16("pc_f", pc_f, m_pc);
            chk1("halted", halted, m_halted);
            chk1("err", err, m_err);
        end
        if (r) begin
            m_pc = 16'h0000; m_ins = NOP; m_p2 = 16'h0000;
            m_busy = 0; m_drop = 0; m_halted = 0; m_err = 0;
            skidq.delete();
            m_known = 1;
        end else begin
            hold = dh | ds;
            if (dn && !e_req) m_err = 1;
            if (fl) begin
                if (bt[0]) m_err = 1;
                m_pc = bt; m_ins = NOP; skidq.delete(); m_halted = 0;
                m_busy = e_req && !dn; m_drop = m_busy; m_addr = e_addr;
            end else begin
                valid = e_req && dn && !m_drop;
                w = imem_rdata;
                if (e_req) begin
                    if (dn) begin m_busy = 0; m_drop = 0; end
                    else begin m_busy = 1; m_addr = e_addr; end
                end
                if (valid) begin
                    nx = m_pc + 16'd2;
                    if (w[15:11] == 5'b00000) m_halted = 1;
                    if (hold) skidq.push_back({w, nx});
                    else begin m_ins = w; m_p2 = nx; end
                    m_pc = nx;
                end else if (!hold) begin
                    if (skidq.size() > 0) {m_ins, m_p2} = skidq.pop_front();
                    else m_ins = NOP;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; data_hazard = 0; dataMem_stall = 0; flush = 0;
        branchTarget = 0; imem_rdata = 0; imem_done = 0;
        for (int i = 0; i < 32768; i++)
            mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
        mem[0] = 16'h0900; mem[1] = 16'h0902; mem[2] = 16'h0904;
        mem[16'h80] = 16'h4321; mem[16'h81] = 16'h1234; mem[16'h82] = 16'hBEEF;
        mem[16'h20] = 16'h5555; mem[16'h08] = 16'h0000; mem[16'h10] = 16'h2222;
        @(posedge clk); #1;

        // Reset state
        step(1, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 16'h0, 0);
        chk16("rst_instr", instruction_fd, 16'h0800);
        chk16("rst_pc", pc_f, 16'h0000);
        chk16("rst_p2", pcPlus2_fd, 16'h0000);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_req", imem_req, 1'b0);

        // Single-cycle hits
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("hit1_instr", instruction_fd, 16'h0900);
        chk16("hit1_p2", pcPlus2_fd, 16'h0002);
        step(0, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("hit3_instr", instruction_fd, 16'h0904);
        chk16("hit3_pc", pc_f, 16'h0006);

        // Miss latency 3 after a redirect to 0x0100
        step(0, 0, 0, 1, 16'h0100, 1);
        chk16("redir_pc", pc_f, 16'h0100);
        step(0, 0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 0, 16'h0, 0);
        chk16("miss_bubble", instruction_fd, 16'h0800);
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("miss_instr", instruction_fd, 16'h4321);
        chk16("miss_pc", pc_f, 16'h0102);

        // Hold while a hit returns 0x1234
        step(0, 1, 0, 0, 16'h0, 1);
        chk16("hold_keep", instruction_fd, 16'h4321);
        chk1("skid_req", imem_req, 1'b0);
        step(0, 1, 0, 0, 16'h0, 0);
        chk16("hold_keep2", instruction_fd, 16'h4321);
        step(0, 0, 0, 0, 16'h0, 0);
        chk16("skid_out", instruction_fd, 16'h1234);
        chk16("skid_p2", pcPlus2_fd, 16'h0104);

        // Flush during a miss; 0xBEEF must be dropped
        step(0, 0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 1, 16'h0040, 0);
        chk16("flush_nop", instruction_fd, 16'h0800);
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("squash_drop", instruction_fd, 16'h0800);
        chk16("squash_addr", imem_addr, 16'h0040);
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("target_instr", instruction_fd, 16'h5555);

        // HALT then redirect
        step(0, 0, 0, 1, 16'h0010, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        chk1("halt_set", halted, 1'b1);
        chk1("halt_req", imem_req, 1'b0);
        chk16("halt_pc", pc_f, 16'h0012);
        step(0, 0, 0, 0, 16'h0, 0);
        chk16("halt_nop", instruction_fd, 16'h0800);
        step(0, 0, 0, 1, 16'h0020, 0);
        chk1("halt_clr", halted, 1'b0);
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("resume_instr", instruction_fd, 16'h2222);

        // Misaligned target, PC wrap, spurious done
        chk1("err_clean", err, 1'b0);
        step(0, 0, 0, 1, 16'h0031, 1);
        chk1("err_align", err, 1'b1);
        chk16("odd_pc", pc_f, 16'h0031);
        step(0, 0, 0, 1, 16'hFFFE, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        chk16("wrap_pc", pc_f, 16'h0000);
        chk16("wrap_p2", pcPlus2_fd, 16'h0000);
        step(0, 1, 0, 0, 16'h0, 1);
        step(0, 1, 0, 0, 16'h0, 1);
        chk1("err_sticky", err, 1'b1);
        step(1, 0, 0, 0, 16'h0, 0);
        chk1("err_rst", err, 1'b0);

        // Randomized traffic with some HALT words in low memory
        for (int i = 0; i < 24; i++) mem[$urandom_range(0, 511)] = 16'h0000;
        for (int c = 0; c < 4000; c++) begin
            logic        r, dh, ds, fl, dn;
            logic [15:0] bt;
            r  = ($urandom_range(0, 199) == 0);
            dh = ($urandom_range(0, 99) < 15);
            ds = ($urandom_range(0, 99) < 8);
            fl = ($urandom_range(0, 99) < 5);
            dn = ($urandom_range(0, 99) < 60);
            bt = 16'($urandom_range(0, 1023)) & 16'hFFFE;
            if ($urandom_range(0, 99) < 4) bt = bt | 16'h0001;
            if ($urandom_range(0, 99) < 3) bt = 16'hFFF8;
            step(r, dh, ds, fl, bt, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
